// File: rtl/deser_pkg.sv
// Shared types and constants for the deser_rx serial receiver.
package deser_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 8'hBC;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

endpackage

// File: rtl/deser_if.sv
// Byte-side valid/ready bus of the receiver: master produces bytes, slave consumes them.
interface deser_if;
    import deser_pkg::*;

    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/deser_hold_reg.sv
// Single-entry valid/ready holding register with sticky overrun flag.
import deser_pkg::*;

module deser_hold_reg (
    input  logic              clock_ser,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              data_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun
);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_ser) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            // A pending byte being consumed this edge frees the slot for the new one.
            if (!data_valid || data_ready) begin
                data_out   <= load_data;
                data_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/deser_rx.sv
// Serial-to-parallel receiver: hunts for the sync word, then assembles LSB-first bytes.
import deser_pkg::*;

module deser_rx #(
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter bit                HUNT_EN   = 1'b1
) (
    input  logic clock_ser,
    input  logic reset,
    input  logic data_in,
    input  logic bit_en,
    input  logic align,
    deser_if.master bus,
    output logic locked,
    output logic overrun
);

    localparam int FILL_W = $clog2(WORD_W + 1);
    localparam int CNT_W  = $clog2(WORD_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
    localparam state_t            STATE_RST = HUNT_EN ? HUNT : LOCKED;

    state_t              state, state_next;
    logic [WORD_W-1:0]   window, window_next, shift_word;
    logic [FILL_W-1:0]   fill, fill_next, fill_inc;
    logic [CNT_W-1:0]    bitcnt, bitcnt_next;
    logic                load;

    assign shift_word = {data_in, window[WORD_W-1:1]};
    assign fill_inc   = (fill == FILL_FULL) ? fill : fill + 1'b1;
    assign locked     = (state == LOCKED);

    always_ff @(posedge clock_ser) begin
        if (reset) begin
            state  <= STATE_RST;
            window <= '0;
            fill   <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_next;
            window <= window_next;
            fill   <= fill_next;
            bitcnt <= bitcnt_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_next  = state;
        window_next = window;
        fill_next   = fill;
        bitcnt_next = bitcnt;
        load        = 1'b0;

        if (align) begin
            // The window is left alone; zero fill makes its stale contents unmatchable.
            state_next  = HUNT;
            fill_next   = '0;
            bitcnt_next = '0;
        end else if (bit_en) begin
            window_next = shift_word;
            fill_next   = fill_inc;
            unique case (state)
                HUNT: begin
                    if (fill_inc == FILL_FULL && shift_word == SYNC_WORD) begin
                        state_next  = LOCKED;
                        bitcnt_next = '0;
                    end
                end
                LOCKED: begin
                    bitcnt_next = bitcnt + 1'b1;
                    // Sync words seen while locked are idle markers and are swallowed.
                    if (bitcnt == CNT_LAST && shift_word != SYNC_WORD) begin
                        load = 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    deser_hold_reg u_hold (
        .clock_ser  (clock_ser),
        .reset      (reset),
        .load       (load),
        .load_data  (shift_word),
        .data_ready (bus.data_ready),
        .data_out   (bus.data_out),
        .data_valid (bus.data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_deser_rx.sv
// Directed plus randomized bench for deser_rx, checked against a queue-based receiver model.
module tb_deser_rx;

    localparam logic [7:0] SYNC = 8'hBC;

    logic clock_ser = 1'b0;
    logic reset     = 1'b1;
    logic data_in   = 1'b0;
    logic bit_en    = 1'b0;
    logic align     = 1'b0;
    logic locked;
    logic overrun;

    deser_if bus ();

    deser_rx dut (
        .clock_ser (clock_ser),
        .reset     (reset),
        .data_in   (data_in),
        .bit_en    (bit_en),
        .align     (align),
        .bus       (bus),
        .locked    (locked),
        .overrun   (overrun)
    );

    always #5 clock_ser = ~clock_ser;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits since the last alignment loss, and the bits of the current word.
    bit         hist[$];
    bit         word[$];
    bit         m_locked = 1'b0;
    bit         m_valid  = 1'b0;
    bit         m_ovr    = 1'b0;
    logic [7:0] m_data   = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit din, input bit en, input bit al, input bit rdy, input bit rst);
        bit         deliver = 1'b0;
        logic [7:0] w       = 8'h00;
        if (rst) begin
            hist.delete();
            word.delete();
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_data   = 8'h00;
            return;
        end
        if (al) begin
            hist.delete();
            word.delete();
            m_locked = 1'b0;
        end else if (en) begin
            if (!m_locked) begin
                hist.push_back(din);
                if (hist.size() > 8) void'(hist.pop_front());
                if (hist.size() == 8) begin
                    for (int i = 0; i < 8; i++) w[i] = hist[i];
                    if (w == SYNC) begin
                        m_locked = 1'b1;
                        word.delete();
                    end
                end
            end else begin
                word.push_back(din);
                if (word.size() == 8) begin
                    for (int i = 0; i < 8; i++) w[i] = word[i];
                    word.delete();
                    deliver = (w != SYNC);
                end
            end
        end
        if (deliver) begin
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit din, input bit en, input bit al, input bit rdy, input bit rst);
        data_in        = din;
        bit_en         = en;
        align          = al;
        bus.data_ready = rdy;
        reset          = rst;
        @(posedge clock_ser);
        model_edge(din, en, al, rdy, rst);
        #1;
        check("data_valid", 32'(bus.data_valid), 32'(m_valid));
        check("locked", 32'(locked), 32'(m_locked));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) check("data_out", 32'(bus.data_out), 32'(m_data));
    endtask

    function automatic bit pick_rdy(input int mode);
        if (mode == 2) return bit'($urandom_range(1));
        return (mode == 1);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int rdy_mode, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max)) step(bit'($urandom_range(1)), 1'b0, 1'b0, pick_rdy(rdy_mode), 1'b0);
            end
            step(b[i], 1'b1, 1'b0, pick_rdy(rdy_mode), 1'b0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'h00);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        logic [7:0] part;
        bus.data_ready = 1'b0;

        // Reset, lock, first byte
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_values("rst0");
        send_byte(SYNC, 0, 0);
        check("lock_after_sync", 32'(locked), 32'h1);
        check("sync_not_delivered", 32'(bus.data_valid), 32'h0);
        send_byte(8'hA5, 0, 0);
        check("first_byte", 32'(bus.data_out), 32'hA5);
        check("first_valid", 32'(bus.data_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Sync word while locked is absorbed
        send_byte(8'h3C, 1, 0);
        check("word_3c", 32'(bus.data_out), 32'h3C);
        send_byte(SYNC, 1, 0);
        check("idle_absorbed", 32'(bus.data_valid), 32'h0);
        send_byte(8'h81, 1, 0);
        check("word_81", 32'(bus.data_out), 32'h81);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun with consumer stalled
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        check("held_11", 32'(bus.data_out), 32'h11);
        check("overrun_set", 32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("consumed", 32'(bus.data_valid), 32'h0);

        // Simultaneous consume-and-load
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(SYNC, 0, 0);
        send_byte(8'h44, 0, 0);
        part = 8'h55;
        for (int i = 0; i < 8; i++) step(part[i], 1'b1, 1'b0, (i == 7), 1'b0);
        check("swap_55", 32'(bus.data_out), 32'h55);
        check("swap_valid", 32'(bus.data_valid), 32'h1);
        check("swap_no_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Align mid-word, then re-lock
        part = 8'h5A;
        for (int i = 0; i < 3; i++) step(part[i], 1'b1, 1'b0, 1'b0, 1'b0);
        step(part[3], 1'b1, 1'b1, 1'b0, 1'b0);
        check("align_unlock", 32'(locked), 32'h0);
        for (int i = 3; i < 8; i++) step(part[i], 1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 0, 0);
        check("no_partial", 32'(bus.data_valid), 32'h0);
        check("still_hunting", 32'(locked), 32'h0);
        send_byte(SYNC, 0, 0);
        check("relock", 32'(locked), 32'h1);

        // Reset mid-word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_reset_values("rst_mid");

        // bit_en gaps inside a word
        send_byte(SYNC, 0, 3);
        send_byte(8'hC3, 0, 3);
        check("gapped_c3", 32'(bus.data_out), 32'hC3);
        check("gapped_valid", 32'(bus.data_valid), 32'h1);

        // Randomized traffic
        send_byte(SYNC, 2, 2);
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(11))
                0: step(bit'($urandom_range(1)), bit'($urandom_range(1)), 1'b1, pick_rdy(2), 1'b0);
                1, 2: send_byte(SYNC, 2, 2);
                3: begin
                    if ($urandom_range(3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    else step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                end
                default: send_byte(8'($urandom_range(255)), 2, 2);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
